frame_receiver: RTL and testbench

Receive-side counterpart of the delay tester's frame sender. Sits on the MAC RX byte interface and parses each incoming Ethernet frame's destination MAC, source MAC and EtherType. It flags frames that match the expected test frame and measures the loop delay in rx_clk cycles, counted from the sender's start-of-transmit pulse to the good-frame status of the matching received frame. It also keeps frame statistics for the host.

---
 rtl/frame_receiver.sv | 199 +++++++++++++++++++
 tb/tb_frame_receiver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_receiver.sv
// frame_receiver
//   Receive side of the loop-delay tester. Parses DST MAC, SRC MAC and
//   EtherType of every frame on the MAC RX byte interface, flags frames that
//   carry the expected test header, measures rx_clk cycles from the sender's
//   tx_start pulse to the matching frame's goodframe status, and keeps frame
//   statistics.
//
// Ports
//   rx_clk, reset_n     clock, synchronous active-low reset
//   mac_rx_data/dvld    received byte stream, contiguous per frame
//   mac_rx_goodframe    1-cycle status: frame OK
//   mac_rx_badframe     1-cycle status: frame errored
//   tx_start            1-cycle pulse: test frame launched, (re)arms the timer
//   frame_match         1-cycle pulse: good frame with expected header
//   delay_valid/value   1-cycle pulse + measured loop delay in cycles
//   delay_timeout       sticky: timer saturated without a match
//   rx_frame_cnt        good frames, rx_match_cnt matching good frames,
//   rx_bad_cnt          bad/runt/oversize/unterminated frames (all wrap)
module frame_receiver #(
    parameter logic [47:0] EXP_DST_ADDR  = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] EXP_SRC_ADDR  = 48'h0012_E228_130E,
    parameter logic [15:0] EXP_ETH_TYPE  = 16'h0806,
    parameter int          MAX_FRAME_LEN = 1518
) (
    input  logic        rx_clk,
    input  logic        reset_n,
    input  logic [7:0]  mac_rx_data,
    input  logic        mac_rx_dvld,
    input  logic        mac_rx_goodframe,
    input  logic        mac_rx_badframe,
    input  logic        tx_start,
    output logic        frame_match,
    output logic        delay_valid,
    output logic [31:0] delay_value,
    output logic        delay_timeout,
    output logic [15:0] rx_frame_cnt,
    output logic [15:0] rx_match_cnt,
    output logic [15:0] rx_bad_cnt
);

    localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);
    localparam logic [10:0] HDR_LEN = 11'd14;

    typedef enum logic [2:0] {
        IDLE, MAC_DST, MAC_SRC, ETH_TYPE, PAYLOAD, WAIT_STATUS, DROP
    } state_t;

    state_t      state, state_nxt;
    logic [10:0] byte_cnt, cnt_inc;
    logic [47:0] dst, src;
    logic [15:0] typ;
    logic        hdr_ok, runt;
    logic        need_gap;      // set by reset: ignore a frame already in flight
    logic [31:0] timer;
    logic        armed;

    // FSM-to-datapath controls
    logic first_byte, next_byte, frame_end;
    logic good_evt, match_evt, bad_evt;
    logic hdr_match;

    assign cnt_inc   = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    assign hdr_match = (dst == EXP_DST_ADDR) && (src == EXP_SRC_ADDR) &&
                       (typ == EXP_ETH_TYPE);

    always_ff @(posedge rx_clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        first_byte = 1'b0;
        next_byte  = 1'b0;
        frame_end  = 1'b0;
        good_evt   = 1'b0;
        match_evt  = 1'b0;
        bad_evt    = 1'b0;
        case (state)
            IDLE: begin
                if (mac_rx_dvld && !need_gap) begin
                    first_byte = 1'b1;
                    state_nxt  = MAC_DST;
                end
            end
            MAC_DST, MAC_SRC, ETH_TYPE, PAYLOAD: begin
                if (!mac_rx_dvld) begin
                    frame_end = 1'b1;
                    state_nxt = WAIT_STATUS;
                end else begin
                    next_byte = 1'b1;
                    // state names where the *next* byte (index cnt_inc) lands
                    if (cnt_inc > MAX_LEN)        state_nxt = DROP;
                    else if (cnt_inc >= HDR_LEN)  state_nxt = PAYLOAD;
                    else if (cnt_inc >= 11'd12)   state_nxt = ETH_TYPE;
                    else if (cnt_inc >= 11'd6)    state_nxt = MAC_SRC;
                    else                          state_nxt = MAC_DST;
                end
            end
            DROP: begin
                if (!mac_rx_dvld) begin
                    frame_end = 1'b1;
                    state_nxt = WAIT_STATUS;
                end
            end
            WAIT_STATUS: begin
                if (mac_rx_goodframe || mac_rx_badframe) begin
                    if (mac_rx_goodframe && !mac_rx_badframe && !runt) begin
                        good_evt  = 1'b1;
                        match_evt = hdr_ok;
                    end else begin
                        bad_evt = 1'b1;
                    end
                    state_nxt = IDLE;
                end
                // a new frame starting here is always captured; without a
                // status the previous frame is counted as unterminated
                if (mac_rx_dvld) begin
                    if (!(mac_rx_goodframe || mac_rx_badframe)) bad_evt = 1'b1;
                    first_byte = 1'b1;
                    state_nxt  = MAC_DST;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // header capture and frame statistics
    always_ff @(posedge rx_clk) begin
        if (!reset_n) begin
            need_gap     <= 1'b1;
            byte_cnt     <= '0;
            dst          <= '0;
            src          <= '0;
            typ          <= '0;
            hdr_ok       <= 1'b0;
            runt         <= 1'b0;
            frame_match  <= 1'b0;
            rx_frame_cnt <= '0;
            rx_match_cnt <= '0;
            rx_bad_cnt   <= '0;
        end else begin
            need_gap <= need_gap && mac_rx_dvld;
            if (first_byte) begin
                byte_cnt <= 11'd1;
                dst      <= {40'd0, mac_rx_data};
            end else if (next_byte) begin
                byte_cnt <= cnt_inc;
                case (state)
                    MAC_DST:  dst <= {dst[39:0], mac_rx_data};
                    MAC_SRC:  src <= {src[39:0], mac_rx_data};
                    ETH_TYPE: typ <= {typ[7:0], mac_rx_data};
                    default:  ;
                endcase
            end
            if (frame_end) begin
                runt   <= (state == DROP) || (byte_cnt < HDR_LEN);
                hdr_ok <= (state != DROP) && (byte_cnt >= HDR_LEN) && hdr_match;
            end
            frame_match <= match_evt;
            if (good_evt)  rx_frame_cnt <= rx_frame_cnt + 16'd1;
            if (match_evt) rx_match_cnt <= rx_match_cnt + 16'd1;
            if (bad_evt)   rx_bad_cnt   <= rx_bad_cnt + 16'd1;
        end
    end

    // loop-delay timer; tx_start wins over match/saturation in its cycle,
    // but a simultaneous match still reports the old timer
    always_ff @(posedge rx_clk) begin
        if (!reset_n) begin
            timer         <= '0;
            armed         <= 1'b0;
            delay_value   <= '0;
            delay_valid   <= 1'b0;
            delay_timeout <= 1'b0;
        end else begin
            delay_valid <= 1'b0;
            if (match_evt && armed) begin
                delay_value <= timer + 32'd1;
                delay_valid <= 1'b1;
            end
            if (tx_start) begin
                timer         <= '0;
                armed         <= 1'b1;
                delay_timeout <= 1'b0;
            end else if (armed) begin
                if (match_evt) begin
                    armed <= 1'b0;
                end else if (timer == 32'hFFFF_FFFF) begin
                    armed         <= 1'b0;
                    delay_timeout <= 1'b1;
                end else begin
                    timer <= timer + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver: reset behaviour, matching/non-matching
// frames with a measured delay, runt/oversize handling, status collisions,
// lost status and timer saturation.
module tb_frame_receiver;

    logic        rx_clk;
    logic        reset_n;
    logic [7:0]  mac_rx_data;
    logic        mac_rx_dvld;
    logic        mac_rx_goodframe;
    logic        mac_rx_badframe;
    logic        tx_start;
    logic        frame_match;
    logic        delay_valid;
    logic [31:0] delay_value;
    logic        delay_timeout;
    logic [15:0] rx_frame_cnt;
    logic [15:0] rx_match_cnt;
    logic [15:0] rx_bad_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] fb [0:2047];

    localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC = 48'h0012_E228_130E;

    frame_receiver dut (
        .rx_clk           (rx_clk),
        .reset_n          (reset_n),
        .mac_rx_data      (mac_rx_data),
        .mac_rx_dvld      (mac_rx_dvld),
        .mac_rx_goodframe (mac_rx_goodframe),
        .mac_rx_badframe  (mac_rx_badframe),
        .tx_start         (tx_start),
        .frame_match      (frame_match),
        .delay_valid      (delay_valid),
        .delay_value      (delay_value),
        .delay_timeout    (delay_timeout),
        .rx_frame_cnt     (rx_frame_cnt),
        .rx_match_cnt     (rx_match_cnt),
        .rx_bad_cnt       (rx_bad_cnt)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build(input logic [47:0] d, input logic [47:0] s,
                         input logic [15:0] t, input int len);
        for (int i = 0; i < len; i++) fb[i] = 8'(i);
        for (int i = 0; i < 6; i++) begin
            fb[i]     = d[47-8*i -: 8];
            fb[6 + i] = s[47-8*i -: 8];
        end
        fb[12] = t[15:8];
        fb[13] = t[7:0];
    endtask

    // st: 0 = no status, 1 = goodframe, 2 = badframe, 3 = both.
    // Returns on the negedge where the outputs of the status edge are visible
    // (or, with no status, on the negedge where dvld was dropped).
    task automatic send_frame(input int len, input int st);
        for (int i = 0; i < len; i++) begin
            @(negedge rx_clk);
            mac_rx_dvld = 1'b1;
            mac_rx_data = fb[i];
        end
        @(negedge rx_clk);
        mac_rx_dvld = 1'b0;
        if (st != 0) begin
            @(negedge rx_clk);
            mac_rx_goodframe = st[0];
            mac_rx_badframe  = st[1];
            @(negedge rx_clk);
            mac_rx_goodframe = 1'b0;
            mac_rx_badframe  = 1'b0;
        end
    endtask

    // three reset edges with dvld toggling; leaves reset asserted, dvld=1
    task automatic do_reset;
        @(negedge rx_clk);
        reset_n = 1'b0; mac_rx_dvld = 1'b1; mac_rx_data = 8'hAA;
        @(negedge rx_clk);
        mac_rx_dvld = 1'b0;
        @(negedge rx_clk);
        mac_rx_dvld = 1'b1;
        @(negedge rx_clk);
    endtask

    task automatic clean_reset;
        do_reset();
        reset_n = 1'b1;
        mac_rx_dvld = 1'b0;
        @(negedge rx_clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; mac_rx_data = '0; mac_rx_dvld = 1'b0;
        mac_rx_goodframe = 1'b0; mac_rx_badframe = 1'b0; tx_start = 1'b0;

        // ---- reset state, then a partial frame after release is ignored
        do_reset();
        chk("rst frame_match", 32'(frame_match), 0);
        chk("rst delay_valid", 32'(delay_valid), 0);
        chk("rst delay_value", delay_value, 0);
        chk("rst timeout", 32'(delay_timeout), 0);
        chk("rst frame_cnt", 32'(rx_frame_cnt), 0);
        chk("rst match_cnt", 32'(rx_match_cnt), 0);
        chk("rst bad_cnt", 32'(rx_bad_cnt), 0);
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge rx_clk);
            mac_rx_data = 8'h55;
        end
        @(negedge rx_clk); mac_rx_dvld = 1'b0;
        @(negedge rx_clk); mac_rx_goodframe = 1'b1;
        @(negedge rx_clk); mac_rx_goodframe = 1'b0;
        @(negedge rx_clk);
        chk("partial frame_cnt", 32'(rx_frame_cnt), 0);
        chk("partial bad_cnt", 32'(rx_bad_cnt), 0);

        // ---- matching 60-byte ARP frame, delay 100
        build(DST, SRC, 16'h0806, 60);
        @(negedge rx_clk); tx_start = 1'b1;
        @(negedge rx_clk); tx_start = 1'b0;
        repeat (37) @(negedge rx_clk);
        send_frame(60, 1);
        chk("arp frame_match", 32'(frame_match), 1);
        chk("arp delay_valid", 32'(delay_valid), 1);
        chk("arp delay_value", delay_value, 100);
        chk("arp frame_cnt", 32'(rx_frame_cnt), 1);
        chk("arp match_cnt", 32'(rx_match_cnt), 1);
        @(negedge rx_clk);
        chk("arp match pulse", 32'(frame_match), 0);
        chk("arp valid pulse", 32'(delay_valid), 0);

        // ---- same frame, EtherType 0800
        build(DST, SRC, 16'h0800, 60);
        send_frame(60, 1);
        chk("ip frame_match", 32'(frame_match), 0);
        chk("ip frame_cnt", 32'(rx_frame_cnt), 2);
        chk("ip match_cnt", 32'(rx_match_cnt), 1);
        chk("ip delay_value", delay_value, 100);

        // ---- runt, oversize, exact-size boundaries
        clean_reset();
        build(DST, SRC, 16'h0806, 10);
        send_frame(10, 1);
        build(DST, SRC, 16'h0806, 1600);
        send_frame(1600, 1);
        chk("runt/over bad_cnt", 32'(rx_bad_cnt), 2);
        chk("runt/over frame_cnt", 32'(rx_frame_cnt), 0);
        build(DST, SRC, 16'h0806, 14);
        send_frame(14, 1);
        chk("len14 frame_match", 32'(frame_match), 1);
        chk("len14 frame_cnt", 32'(rx_frame_cnt), 1);
        build(DST, SRC, 16'h0806, 1518);
        send_frame(1518, 1);
        chk("len1518 frame_match", 32'(frame_match), 1);
        chk("len1518 match_cnt", 32'(rx_match_cnt), 2);
        build(DST, SRC, 16'h0806, 1519);
        send_frame(1519, 1);
        chk("len1519 frame_match", 32'(frame_match), 0);
        chk("len1519 bad_cnt", 32'(rx_bad_cnt), 3);
        chk("len1519 frame_cnt", 32'(rx_frame_cnt), 2);
        build(DST, 48'h0012_E228_130F, 16'h0806, 60);
        send_frame(60, 1);
        chk("badsrc frame_match", 32'(frame_match), 0);
        chk("badsrc match_cnt", 32'(rx_match_cnt), 2);

        // ---- good+bad together, then lost status
        clean_reset();
        build(DST, SRC, 16'h0806, 60);
        send_frame(60, 3);
        chk("both frame_match", 32'(frame_match), 0);
        chk("both bad_cnt", 32'(rx_bad_cnt), 1);
        chk("both frame_cnt", 32'(rx_frame_cnt), 0);
        send_frame(60, 0);
        send_frame(60, 1);
        chk("lost bad_cnt", 32'(rx_bad_cnt), 2);
        chk("lost frame_match", 32'(frame_match), 1);
        chk("lost match_cnt", 32'(rx_match_cnt), 1);
        chk("unarmed delay_valid", 32'(delay_valid), 0);
        chk("unarmed delay_value", delay_value, 0);

        // ---- timer saturation
        clean_reset();
        tx_start = 1'b1;
        @(negedge rx_clk); tx_start = 1'b0;
        repeat (5) @(negedge rx_clk);
        force dut.timer = 32'hFFFF_FFFE;
        release dut.timer;
        @(negedge rx_clk);
        chk("sat timeout +1", 32'(delay_timeout), 0);
        @(negedge rx_clk);
        chk("sat timeout +2", 32'(delay_timeout), 1);
        repeat (3) @(negedge rx_clk);
        chk("sat timeout sticky", 32'(delay_timeout), 1);
        tx_start = 1'b1;
        @(negedge rx_clk); tx_start = 1'b0;
        chk("restart timeout", 32'(delay_timeout), 0);
        send_frame(60, 1);
        chk("restart delay_valid", 32'(delay_valid), 1);
        chk("restart delay_value", delay_value, 63);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
